// File: rtl/pipe_ctrl.sv
// Pipeline control unit: turns per-stage stall requests and a redirect into the
// stall bus, tracks per-stage valid bits, and keeps perf counters and a hang watchdog.
module pipe_ctrl #(
  parameter int STAGES      = 5,
  parameter int FLUSH_STAGE = 3,
  parameter int CNT_W       = 32,
  parameter int HANG_LIMIT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  output logic [STAGES:0]   stall,
  output logic [STAGES-1:0] valid,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              hang
);

  localparam logic [CNT_W-1:0] HANG_LIM_C = CNT_W'(HANG_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [STAGES:0]   stall_raw;
  logic [STAGES-1:0] bubble;
  logic              any_stall;
  logic              any_bubble;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic              hang_q, hang_d;

  // A stalled stage also holds every younger stage and the PC, so hold bit j+1
  // is the OR of requests from stage j upward.
  always_comb begin
    stall_raw    = '0;
    stall_raw[0] = |stallreq;
    for (int j = 0; j < STAGES; j++) begin
      stall_raw[j+1] = |(stallreq >> j);
    end
  end

  assign flush     = flush_req & ~rst;
  assign stall     = (rst || flush_req) ? '0 : stall_raw;
  assign new_pc    = flush ? flush_pc : 32'h0;
  assign any_stall = |stall;

  // The stall bus is a run of ones from bit 0, so at most one boundary exists.
  always_comb begin
    bubble = '0;
    for (int j = 1; j < STAGES; j++) begin
      bubble[j] = stall[j] & ~stall[j+1];
    end
  end

  assign any_bubble = |bubble;

  always_comb begin
    valid_d = '0;
    if (flush && (FLUSH_STAGE > 0)) begin
      valid_d[0] = 1'b0;
    end else if (stall[1]) begin
      valid_d[0] = valid_q[0];
    end else begin
      valid_d[0] = 1'b1;
    end
    for (int j = 1; j < STAGES; j++) begin
      if (flush && (j < FLUSH_STAGE)) begin
        valid_d[j] = 1'b0;
      end else if (stall[j+1]) begin
        valid_d[j] = valid_q[j];
      end else if (bubble[j]) begin
        valid_d[j] = 1'b0;
      end else begin
        valid_d[j] = valid_q[j-1];
      end
    end
  end

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q + CNT_ONE;
    stall_cnt_d  = any_stall ? (stall_cnt_q + CNT_ONE) : stall_cnt_q;
    bubble_cnt_d = any_bubble ? (bubble_cnt_q + CNT_ONE) : bubble_cnt_q;
    retire_cnt_d = valid_q[STAGES-1] ? (retire_cnt_q + CNT_ONE) : retire_cnt_q;
  end

  // Watchdog run length saturates at the limit; hang latches on the edge it arrives.
  always_comb begin
    run_d  = run_q;
    hang_d = hang_q;
    if (!any_stall || flush) begin
      run_d = '0;
    end else if (run_q != HANG_LIM_C) begin
      run_d = run_q + CNT_ONE;
    end
    if (run_d == HANG_LIM_C) begin
      hang_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      cycle_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      retire_cnt_q <= '0;
      run_q        <= '0;
      hang_q       <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      cycle_cnt_q  <= cycle_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      run_q        <= run_d;
      hang_q       <= hang_d;
    end
  end

  assign valid      = valid_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign retire_cnt = retire_cnt_q;
  assign hang       = hang_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected valid vectors queued per step and
// compared after each edge; counters, stall bus and hang checked at fixed points.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  stallreq;
  logic        flush_req;
  logic [31:0] flush_pc;

  logic [5:0]  stall;
  logic [4:0]  valid;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] cycle_cnt, stall_cnt, bubble_cnt, retire_cnt;
  logic        hang;

  logic [5:0]  w_stall;
  logic [4:0]  w_valid;
  logic        w_flush;
  logic [31:0] w_new_pc;
  logic [3:0]  w_cycle_cnt, w_stall_cnt, w_bubble_cnt, w_retire_cnt;
  logic        w_hang;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  pipe_ctrl #(.STAGES(5), .FLUSH_STAGE(3), .CNT_W(32), .HANG_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .valid(valid), .flush(flush), .new_pc(new_pc),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .retire_cnt(retire_cnt), .hang(hang)
  );

  pipe_ctrl #(.STAGES(5), .FLUSH_STAGE(3), .CNT_W(4), .HANG_LIMIT(8)) dut_w (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(w_stall), .valid(w_valid), .flush(w_flush), .new_pc(w_new_pc),
    .cycle_cnt(w_cycle_cnt), .stall_cnt(w_stall_cnt), .bubble_cnt(w_bubble_cnt),
    .retire_cnt(w_retire_cnt), .hang(w_hang)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, check the combinational outputs, queue the
  // expected valid vector and compare it after the edge.
  task automatic step(input logic [4:0] sr, input logic fr, input logic [31:0] pc,
                      input logic [5:0] exp_stall, input logic [4:0] exp_valid);
    logic [4:0] ev;
    stallreq  = sr;
    flush_req = fr;
    flush_pc  = pc;
    #1;
    chk("stall", stall, exp_stall);
    chk("flush", flush, fr);
    chk("new_pc", new_pc, fr ? pc : 32'h0);
    exp_q.push_back(exp_valid);
    @(posedge clk);
    #1;
    ev = exp_q.pop_front();
    chk("valid", valid, ev);
  endtask

  initial begin
    logic [4:0] ev;
    rst       = 1'b1;
    stallreq  = '0;
    flush_req = 1'b0;
    flush_pc  = '0;
    @(posedge clk);
    #1;

    // requests while in reset are masked
    stallreq  = 5'b00100;
    flush_req = 1'b1;
    flush_pc  = 32'hDEAD0000;
    #1;
    chk("rst_stall", stall, 6'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_new_pc", new_pc, 32'h0);
    exp_q.push_back(5'b0);
    @(posedge clk);
    #1;
    ev = exp_q.pop_front();
    chk("rst_valid", valid, ev);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_bubble", bubble_cnt, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_hang", hang, 1'b0);
    chk("rst_w_cycle", w_cycle_cnt, 4'd0);

    // reset release, pipe fills
    rst = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      ev = (i >= 5) ? 5'b11111 : 5'((1 << i) - 1);
      step(5'b0, 1'b0, 32'h0, 6'b0, ev);
      if (i == 5) chk("retire_edge5", retire_cnt, 32'd0);
      if (i == 6) chk("retire_edge6", retire_cnt, 32'd1);
    end
    chk("fill_cycle", cycle_cnt, 32'd17);
    chk("fill_w_cycle_wrap", w_cycle_cnt, 4'd1);
    chk("fill_retire", retire_cnt, 32'd12);
    chk("fill_stall_cnt", stall_cnt, 32'd0);
    chk("fill_bubble", bubble_cnt, 32'd0);

    // ID stall: bubble into EX
    step(5'b00010, 1'b0, 32'h0, 6'b000111, 5'b11011);
    chk("id_bubble", bubble_cnt, 32'd1);
    chk("id_stall_cnt", stall_cnt, 32'd1);
    chk("id_retire", retire_cnt, 32'd13);
    step(5'b0, 1'b0, 32'h0, 6'b0, 5'b10111);
    step(5'b0, 1'b0, 32'h0, 6'b0, 5'b01111);
    step(5'b0, 1'b0, 32'h0, 6'b0, 5'b11111);
    chk("id_retire_after", retire_cnt, 32'd15);

    // ID+EX stall: bubble into MEM
    step(5'b00110, 1'b0, 32'h0, 6'b001111, 5'b10111);
    chk("ex_bubble", bubble_cnt, 32'd2);
    chk("ex_stall_cnt", stall_cnt, 32'd2);
    chk("ex_retire", retire_cnt, 32'd16);
    step(5'b0, 1'b0, 32'h0, 6'b0, 5'b01111);
    step(5'b0, 1'b0, 32'h0, 6'b0, 5'b11111);

    // flush wins over a simultaneous stall request
    step(5'b00100, 1'b1, 32'hBFC00380, 6'b0, 5'b11000);
    chk("flush_stall_cnt", stall_cnt, 32'd2);
    chk("flush_bubble", bubble_cnt, 32'd2);
    chk("flush_retire", retire_cnt, 32'd18);
    step(5'b0, 1'b0, 32'h0, 6'b0, 5'b10001);
    step(5'b0, 1'b0, 32'h0, 6'b0, 5'b00011);
    step(5'b0, 1'b0, 32'h0, 6'b0, 5'b00111);
    step(5'b0, 1'b0, 32'h0, 6'b0, 5'b01111);
    step(5'b0, 1'b0, 32'h0, 6'b0, 5'b11111);
    chk("refill_retire", retire_cnt, 32'd20);

    // WB stall holds everything without a bubble
    step(5'b10000, 1'b0, 32'h0, 6'b111111, 5'b11111);
    chk("wb_bubble", bubble_cnt, 32'd2);
    chk("wb_stall_cnt", stall_cnt, 32'd3);
    chk("wb_hang", hang, 1'b0);
    step(5'b0, 1'b0, 32'h0, 6'b0, 5'b11111);
    chk("wb_retire", retire_cnt, 32'd22);

    // IF stall held for the watchdog limit of 4
    step(5'b00001, 1'b0, 32'h0, 6'b000011, 5'b11101);
    chk("hang_e1", hang, 1'b0);
    step(5'b00001, 1'b0, 32'h0, 6'b000011, 5'b11001);
    chk("hang_e2", hang, 1'b0);
    step(5'b00001, 1'b0, 32'h0, 6'b000011, 5'b10001);
    chk("hang_e3", hang, 1'b0);
    step(5'b00001, 1'b0, 32'h0, 6'b000011, 5'b00001);
    chk("hang_e4", hang, 1'b1);
    step(5'b0, 1'b0, 32'h0, 6'b0, 5'b00011);
    chk("hang_sticky", hang, 1'b1);
    chk("hang_bubble", bubble_cnt, 32'd6);
    chk("hang_stall_cnt", stall_cnt, 32'd7);
    chk("hang_retire", retire_cnt, 32'd26);
    chk("hang_cycle", cycle_cnt, 32'd37);

    // reset asserted mid-stall with a flush pending
    stallreq  = 5'b00001;
    flush_req = 1'b1;
    flush_pc  = 32'h12345678;
    rst       = 1'b1;
    #1;
    chk("rst2_stall", stall, 6'b0);
    chk("rst2_flush", flush, 1'b0);
    chk("rst2_new_pc", new_pc, 32'h0);
    exp_q.push_back(5'b0);
    @(posedge clk);
    #1;
    ev = exp_q.pop_front();
    chk("rst2_valid", valid, ev);
    chk("rst2_hang", hang, 1'b0);
    chk("rst2_cycle", cycle_cnt, 32'd0);
    chk("rst2_retire", retire_cnt, 32'd0);
    chk("rst2_stall_cnt", stall_cnt, 32'd0);
    chk("rst2_bubble", bubble_cnt, 32'd0);
    rst = 1'b0;
    step(5'b0, 1'b0, 32'h0, 6'b0, 5'b00001);
    chk("restart_cycle", cycle_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the in-order CPU core. It turns per-stage stall requests and a flush request into the pipeline stall bus, and tracks a per-stage valid bit so inserted bubbles are visible to later stages and to debug. It also keeps wrapping performance counters and raises a sticky hang flag when the pipeline stays stalled too long. It replaces the fixed 5-stage stall controller and sits beside the stage modules in the core top.

## Interface
- STAGES, 5, number of pipeline stages; index 0 = IF, STAGES-1 = WB.
- FLUSH_STAGE, 3, the flush kills stages 0..FLUSH_STAGE-1; stages FLUSH_STAGE and older drain normally. Range 1..STAGES-1.
- CNT_W, 32, width of the performance counters.
- HANG_LIMIT, 1024, count of consecutive stalled cycles that sets `hang`. Must be ≥1 and < 2^CNT_W.
- clk  in  1  core clock; one clock domain; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stallreq  in  STAGES  bit k = stage k cannot complete this cycle.
- flush_req  in  1  redirect request (exception or eret) raised this cycle.
- flush_pc  in  32  redirect target; sampled only when flush_req=1.
- stall  out  STAGES+1  stall bus; bit 0 = PC hold, bit k+1 = stage k register hold.
- valid  out  STAGES  registered; bit k = stage k holds a real instruction.
- flush  out  1  combinational copy of flush_req with rst masked.
- new_pc  out  32  flush_pc when flush=1, else 0.
- cycle_cnt, stall_cnt, bubble_cnt, retire_cnt  out  CNT_W each  performance counters.
- hang  out  1  sticky watchdog flag.

## Operation
- Stall bus is combinational. Let k = the highest set index of stallreq. Then stall[k+1:0] = all ones and the upper bits are 0. If no bit is set, stall = 0.
- Flush has priority. When flush=1, stall = 0 regardless of stallreq.
- While rst=1: stall=0, flush=0 and new_pc=0.
- Let hold(j) = stall[j+1]. A bubble enters stage j (j≥1) when stall[j]=1 and stall[j+1]=0.
- valid[j] update on each rising edge, highest priority first:
  - rst: valid[j] ← 0.
  - flush and j < FLUSH_STAGE: valid[j] ← 0.
  - hold(j): valid[j] is kept.
  - j = 0: valid[0] ← 1.
  - bubble into j: valid[j] ← 0.
  - otherwise: valid[j] ← valid[j-1].
- Counters are cleared by rst. They wrap modulo 2^CNT_W.
  - cycle_cnt +1 every cycle.
  - stall_cnt +1 when stall≠0.
  - bubble_cnt +1 per cycle in which any bubble is inserted. At most one bubble is inserted per cycle.
  - retire_cnt +1 when valid[STAGES-1]=1.
- Watchdog: an internal run counter increments while stall≠0, saturates at HANG_LIMIT, and clears on a cycle with stall=0 or on flush. When run reaches HANG_LIMIT, hang ← 1 on that edge. hang clears only on rst.

## Timing
- stall, flush and new_pc have zero latency: they are combinational from the same-cycle inputs.
- valid, the counters and hang update one edge after the causing condition.
- Reset values: valid=0, all counters=0, hang=0, watchdog run=0.
- After rst falls, valid[0]=1 after the first edge. valid[STAGES-1] first becomes 1 after STAGES edges if there are no stalls.
- Simultaneous flush and stallreq: the flush wins, the stall is dropped for that cycle, and stall_cnt does not increment.
- rst asserted mid-stall or mid-flush: all state returns to reset values on that edge.
- A stallreq on the last stage (k = STAGES-1) holds the whole pipe. No bubble is inserted and bubble_cnt is unchanged.

## Test plan
- Reset release with no requests, STAGES=5 → valid = 00001, 00011, 00111, 01111, 11111 on successive edges; retire_cnt=1 on the 6th edge.
- stallreq=00010 (ID) held for 1 cycle with the pipe full → stall=000111; next edge valid[2]=0; bubble_cnt=1; stall_cnt=1.
- stallreq=00110 (ID and EX) → stall=001111. The bubble enters MEM: valid[3]=0 next edge.
- flush_req=1, flush_pc=0xBFC00380, stallreq=00100, pipe full, FLUSH_STAGE=3 → same cycle stall=0, flush=1, new_pc=0xBFC00380; next edge valid[2:0]=000 and valid[4:3] shifted normally.
- HANG_LIMIT=4, stallreq=00001 held → hang=1 after the 4th stalled edge and stays 1 after stallreq drops; rst clears it.
- CNT_W=4, run 17 unstalled cycles after reset → cycle_cnt=1 (wrapped).
